// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and limits for the memory cell pipe
package memory_pkg;

  typedef enum logic {MEM_IDLE, MEM_CLEAR} mem_state_t;

  localparam int MEM_MAX_READ_LATENCY = 2;

endpackage

// File: rtl/memory_read_pipe.sv
// rtl/memory_read_pipe.sv - LATENCY-deep {valid, data} shift; data stages only load on valid
module memory_read_pipe
  import memory_pkg::*;
#(
  parameter int BIT_SIZE = 16,
  parameter int LATENCY  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [BIT_SIZE-1:0] in_data,
  output logic                out_valid,
  output logic [BIT_SIZE-1:0] out_data
);

  localparam int LAT = (LATENCY < 1) ? 1 :
                       (LATENCY > MEM_MAX_READ_LATENCY) ? MEM_MAX_READ_LATENCY : LATENCY;

  logic [LAT-1:0]      vld;
  logic [BIT_SIZE-1:0] dat [LAT];

  // Gating data loads on valid keeps out_data stable between read results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_data  = dat[LAT-1];

endmodule

// File: rtl/memory_cell_pipe.sv
// rtl/memory_cell_pipe.sv - memory array with pipelined reads and sequenced bulk clear
// Optional write-first forwarding on same-address read/write: MEMORY_FORWARD_EN
module memory_cell_pipe
  import memory_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int BIT_SIZE     = 16,
  parameter int READ_LATENCY = 1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                write_enable,
  input  logic [AW-1:0]       write_addr,
  input  logic [BIT_SIZE-1:0] data_in,
  input  logic                read_enable,
  input  logic [AW-1:0]       read_addr,
  output logic [BIT_SIZE-1:0] data_out,
  output logic                read_valid,
  input  logic                clear,
  output logic                busy
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [BIT_SIZE-1:0] mem [DEPTH];
  mem_state_t          state;
  logic [AW-1:0]       clr_cnt;

  logic                accept, wr_fire, rd_fire, wr_in_range, rd_in_range;
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [BIT_SIZE-1:0] mem_wdata, rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MEM_IDLE;
      clr_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: if (clear) begin
          state   <= MEM_CLEAR;
          clr_cnt <= '0;
          busy    <= 1'b1;
        end
        MEM_CLEAR: if (clr_cnt == LAST) begin
          state <= MEM_IDLE;
          busy  <= 1'b0;
        end else begin
          clr_cnt <= clr_cnt + AW'(1);
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

  assign accept      = (state == MEM_IDLE) && !clear;
  assign wr_in_range = int'(write_addr) < DEPTH;
  assign rd_in_range = int'(read_addr) < DEPTH;
  assign wr_fire     = accept && write_enable && wr_in_range;
  assign rd_fire     = accept && read_enable;

  // Gating on rst_n keeps an aborted clear from zeroing one more entry.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_addr;
    mem_wdata = data_in;
    if (state == MEM_CLEAR) begin
      mem_we    = rst_n;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_we = rst_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rd_data = '0;
    if (rd_in_range) begin
      rd_data = mem[read_addr];
`ifdef MEMORY_FORWARD_EN
      if (write_enable && (write_addr == read_addr)) rd_data = data_in;
`endif
    end
  end

  memory_read_pipe #(
    .BIT_SIZE (BIT_SIZE),
    .LATENCY  (READ_LATENCY)
  ) u_read_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_fire),
    .in_data   (rd_data),
    .out_valid (read_valid),
    .out_data  (data_out)
  );

endmodule

// File: tb/tb_memory_cell_pipe.sv
// tb/tb_memory_cell_pipe.sv - scoreboard bench over DEPTH=2/L1, DEPTH=5/L2 and DEPTH=8/L1 instances
module tb_memory_cell_pipe;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

`ifdef MEMORY_FORWARD_EN
  localparam logic [15:0] FWD_EXP = 16'h00FF;
`else
  localparam logic [15:0] FWD_EXP = 16'h1234;
`endif

  logic clk = 1'b0;
  logic rst_n, rst2_n;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;

  exp_t q0[$], q1[$], q2[$];

  logic        we0, re0, clr0, rv0, busy0;
  logic [0:0]  wa0, ra0;
  logic [15:0] di0, dout0;
  logic        we1, re1, clr1, rv1, busy1;
  logic [2:0]  wa1, ra1;
  logic [15:0] di1, dout1;
  logic        we2, re2, clr2, rv2, busy2;
  logic [2:0]  wa2, ra2;
  logic [15:0] di2, dout2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_cell_pipe #(.DEPTH(2), .BIT_SIZE(16), .READ_LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n), .write_enable(we0), .write_addr(wa0), .data_in(di0),
    .read_enable(re0), .read_addr(ra0), .data_out(dout0), .read_valid(rv0),
    .clear(clr0), .busy(busy0));

  memory_cell_pipe #(.DEPTH(5), .BIT_SIZE(16), .READ_LATENCY(2)) u1 (
    .clk(clk), .rst_n(rst_n), .write_enable(we1), .write_addr(wa1), .data_in(di1),
    .read_enable(re1), .read_addr(ra1), .data_out(dout1), .read_valid(rv1),
    .clear(clr1), .busy(busy1));

  memory_cell_pipe #(.DEPTH(8), .BIT_SIZE(16), .READ_LATENCY(1)) u2 (
    .clk(clk), .rst_n(rst2_n), .write_enable(we2), .write_addr(wa2), .data_in(di2),
    .read_enable(re2), .read_addr(ra2), .data_out(dout2), .read_valid(rv2),
    .clear(clr2), .busy(busy2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Requests are driven just after an edge; the next edge samples them.
  task automatic rd0(input int a, input logic [15:0] d);
    ra0 = 1'(a); re0 = 1'b1; q0.push_back('{cyc + 1, d});
  endtask
  task automatic rd1(input int a, input logic [15:0] d);
    ra1 = 3'(a); re1 = 1'b1; q1.push_back('{cyc + 2, d});
  endtask
  task automatic rd2(input int a, input logic [15:0] d);
    ra2 = 3'(a); re2 = 1'b1; q2.push_back('{cyc + 1, d});
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rv0) begin
      if (q0.size() == 0) check("u0 spurious read_valid", 32'(rv0), 32'd0);
      else begin
        e = q0.pop_front();
        check("u0 read latency", cyc, e.due);
        check("u0 read data", 32'(dout0), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rv1) begin
      if (q1.size() == 0) check("u1 spurious read_valid", 32'(rv1), 32'd0);
      else begin
        e = q1.pop_front();
        check("u1 read latency", cyc, e.due);
        check("u1 read data", 32'(dout1), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rv2) begin
      if (q2.size() == 0) check("u2 spurious read_valid", 32'(rv2), 32'd0);
      else begin
        e = q2.pop_front();
        check("u2 read latency", cyc, e.due);
        check("u2 read data", 32'(dout2), 32'(e.data));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    {we0, re0, clr0, wa0, ra0, di0} = '0;
    {we1, re1, clr1, wa1, ra1, di1} = '0;
    {we2, re2, clr2, wa2, ra2, di2} = '0;
    tick; tick;
    check("u0 reset data_out", 32'(dout0), 32'd0);
    check("u0 reset read_valid", 32'(rv0), 32'd0);
    check("u0 reset busy", 32'(busy0), 32'd0);
    check("u1 reset data_out", 32'(dout1), 32'd0);
    check("u2 reset busy", 32'(busy2), 32'd0);
    rst_n = 1'b1; rst2_n = 1'b1;
    tick;

    // u0: basic write then back-to-back reads
    we0 = 1; wa0 = 1; di0 = 16'h1234; tick;
    wa0 = 0; di0 = 16'hBEEF; tick;
    we0 = 0; rd0(1, 16'h1234); tick;
    rd0(0, 16'hBEEF); tick;
    re0 = 0; tick; tick;
    check("u0 data_out hold", 32'(dout0), 32'hBEEF);
    check("u0 read_valid idle", 32'(rv0), 32'd0);

    // u0: same-cycle read/write to one address
    we0 = 1; wa0 = 1; di0 = 16'h00FF; rd0(1, FWD_EXP); tick;
    we0 = 0; rd0(1, 16'h00FF); tick;
    re0 = 0;

    // u0: clear beats a same-cycle write and read
    clr0 = 1; we0 = 1; wa0 = 0; di0 = 16'h9999; re0 = 1; ra0 = 1; tick;
    clr0 = 0; we0 = 0; re0 = 0; tick; tick;
    check("u0 busy after clear", 32'(busy0), 32'd0);
    rd0(0, 16'h0000); tick;
    rd0(1, 16'h0000); tick;
    re0 = 0; tick; tick;

    // u1: fill, out-of-range access, in-flight read vs later write
    for (int i = 0; i < 5; i++) begin
      we1 = 1; wa1 = 3'(i); di1 = 16'hAAAA; tick;
    end
    we1 = 0;
    rd1(2, 16'hAAAA); tick;
    re1 = 0; we1 = 1; wa1 = 6; di1 = 16'h1111; tick;
    we1 = 0; rd1(6, 16'h0000); tick;
    rd1(3, 16'hAAAA); tick;
    re1 = 0; we1 = 1; wa1 = 3; di1 = 16'h7777; tick;
    we1 = 0; rd1(3, 16'h7777); tick;
    re1 = 0; tick; tick; tick;

    // u1: bulk clear with accesses attempted while busy
    clr1 = 1; tick;
    clr1 = 0; we1 = 1; wa1 = 2; di1 = 16'h5555; re1 = 1; ra1 = 3;
    check("u1 busy k=0", 32'(busy1), 32'd1);
    tick;
    we1 = 0; re1 = 0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("u1 busy k=%0d", k), 32'(busy1), (k < 5) ? 32'd1 : 32'd0);
      if (k < 5) tick;
    end
    for (int i = 0; i < 5; i++) begin
      rd1(i, 16'h0000); tick;
    end
    rd1(2, 16'h0000); tick;
    re1 = 0; tick; tick; tick;

    // u2: fill, then reset flushes an in-flight read
    for (int i = 0; i < 8; i++) begin
      we2 = 1; wa2 = 3'(i); di2 = 16'h0100 + 16'(i); tick;
    end
    we2 = 0; ra2 = 5; re2 = 1; tick;
    re2 = 0;
    check("u2 valid before reset", 32'(rv2), 32'd1);
    check("u2 data before reset", 32'(dout2), 32'h0105);
    rst2_n = 0; #1;
    check("u2 valid flushed", 32'(rv2), 32'd0);
    check("u2 data_out reset", 32'(dout2), 32'd0);
    tick; rst2_n = 1; tick;

    // u2: reset three cycles into a clear
    clr2 = 1; tick;
    clr2 = 0; tick; tick; tick;
    check("u2 busy mid clear", 32'(busy2), 32'd1);
    rst2_n = 0; #1;
    check("u2 busy after abort", 32'(busy2), 32'd0);
    tick; rst2_n = 1; tick;
    for (int i = 0; i < 8; i++) begin
      rd2(i, (i < 3) ? 16'h0000 : 16'h0100 + 16'(i)); tick;
    end
    re2 = 0; tick; tick; tick;

    check("u0 outstanding reads", q0.size(), 32'd0);
    check("u1 outstanding reads", q1.size(), 32'd0);
    check("u2 outstanding reads", q2.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/memory_cell_pipe.md
# memory_cell_pipe

Parametrised successor to the two-port memory cell, used as weight/activation storage in the accelerator datapath. It provides:
- one synchronous write port;
- one read port with a request/valid handshake and a registered, configurable-latency read pipeline;
- a sequenced bulk-clear operation that zeroes every entry.

Layer controllers use it wherever a read must be timed against a valid strobe rather than sampled combinationally.

## Interface
- DEPTH, 2: number of entries; must be ≥ 2 and need not be a power of two.
- BIT_SIZE, 16: entry width in bits.
- READ_LATENCY, 1: cycles from read request to `read_valid`; legal values are 1 and 2.

Ports (AW = $clog2(DEPTH)):
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- write_enable  in  1  write request.
- write_addr  in  AW  write address.
- data_in  in  BIT_SIZE  write data.
- read_enable  in  1  read request.
- read_addr  in  AW  read address.
- data_out  out  BIT_SIZE  registered read data.
- read_valid  out  1  `data_out` holds the result of a read request.
- clear  in  1  single-cycle pulse that starts a bulk clear.
- busy  out  1  a clear is in progress.

## Operation
- State machine, 2 states:
  - IDLE: `clear`=1 → CLEAR, clear counter loads 0.
  - CLEAR: each cycle writes 0 to entry[counter]. When counter == DEPTH-1, write that entry and return to IDLE; otherwise counter += 1.
- In IDLE:
  - `write_enable`=1 writes `data_in` to `write_addr` at the clock edge.
  - `read_enable`=1 samples `array[read_addr]` into the read pipe.
- In CLEAR:
  - `write_enable`, `read_enable` and `clear` are ignored.
  - Reads already in the pipe complete normally.
- `clear` asserted in IDLE in the same cycle as `write_enable` or `read_enable`: `clear` wins and the access is dropped.
- Out-of-range addresses (≥ DEPTH, non-power-of-two case): writes are dropped; reads return 0 and still raise `read_valid`.
- Read data is the array value at the sampling edge. A write to the same address on a later cycle does not alter a read already in flight.
- Same-cycle read and write to the same address: the result depends on `MEMORY_FORWARD_EN` (see Configuration).
- Memory contents are not reset. Pipeline registers are reset.

## Timing
Reset values:
- `data_out` = 0
- `read_valid` = 0
- `busy` = 0
- state = IDLE
- clear counter = 0

Read latency:
- READ_LATENCY=1: a request at edge N gives `read_valid`=1 and valid `data_out` during cycle N+1.
- READ_LATENCY=2: the same appears during cycle N+2.
- `read_valid` is a one-cycle pulse per request. Back-to-back requests give a throughput of 1 read per cycle.
- `data_out` holds its last value when `read_valid`=0.

Clear timing:
- `clear` sampled at edge N: `busy`=1 from cycle N+1 through cycle N+DEPTH.
- `busy`=0 at cycle N+DEPTH+1; new accesses are accepted from that edge.
- Total clear duration is DEPTH cycles.

Write timing: a write at edge N is visible to a read request sampled at edge N+1.

Reset mid-operation: asserting `rst_n`=0 asynchronously aborts a clear and flushes the read pipe.
- Entries already zeroed stay zeroed; the rest keep their prior contents.
- `busy` and `read_valid` drop to 0 immediately.

## Configuration
- `MEMORY_FORWARD_EN` defined:
  - On a same-cycle read and write to the same address in IDLE, the read returns `data_in` (write-first).
  - Adds a BIT_SIZE-wide mux and an AW-bit comparator in front of the pipe.
- Not defined:
  - The read returns the old array value (read-first).
  - No comparator logic is present.

## Structure
- `memory_pkg` contains:
  - `mem_state_t` enum {MEM_IDLE, MEM_CLEAR};
  - localparam `MEM_MAX_READ_LATENCY` = 2.
- Sub-module `memory_read_pipe`: a READ_LATENCY-deep shift of {valid, data} with async reset, instantiated once.
- The top level holds the array, the clear FSM/counter and the forward mux.

## Test plan
- Reset, then write 0x1234@1 and 0xBEEF@0, then read 1 and 0 on consecutive cycles (READ_LATENCY=1) → `read_valid` pulses in cycles 2 and 3 with `data_out` = 0x1234 then 0xBEEF.
- DEPTH=5, READ_LATENCY=2: write 0xAAAA to all 5 entries, pulse `clear` → `busy` high exactly 5 cycles; then reads of 0..4 return 0x0000, each valid 2 cycles after request.
- During `busy`, write 0x5555@2 and read 3 → write dropped and no `read_valid`; after clear, read 2 returns 0x0000.
- Same-cycle write 0x00FF@1 and read@1, with 1 holding 0x1234 → returns 0x00FF with `MEMORY_FORWARD_EN`, 0x1234 without it.
- Pulse `clear` on a DEPTH=8 instance and drop `rst_n` 3 cycles in → `busy`=0 immediately; entries 0–2 read 0 and entries 3–7 keep prior values.
- Read request at edge N, write 0x7777 to the same address at N+1 (READ_LATENCY=2) → `data_out` at N+2 is the pre-write value.
